// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding, line constants and a
// small parity helper usable by both the receiver and the matching transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  localparam logic UART_IDLE_LEVEL    = 1'b1;
  localparam int   UART_MAX_DATA_BITS = 9;

  // XOR of all bits; narrower words are zero-extended so the result is unchanged.
  function automatic logic uart_xor_bits(input logic [UART_MAX_DATA_BITS-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: free-running divide-by-CLK_DIV counter that
// emits a one-clock tick on wrap. 'clear' restarts the count so that bit
// timing can be aligned to a detected start edge.
module uart_baud_tick #(
  parameter int CLK_DIV = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  // Next count: clear wins, otherwise wrap at CLK_DIV-1.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // Divider register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver on the system clock. Mid-bit sampling with an
// internal oversampling tick, 5..9 data bits, 1 or 2 stop bits, framing and
// overrun detection, valid/ready output handshake.
// Optional parity bit is compiled in with `define UART_RX_PARITY_EN
// (sense chosen by PARITY_ODD); without it parity_err is tied low.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 27,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int            TW        = $clog2(OVERSAMPLE);
  localparam int            BW        = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  logic rx_meta_q, rx_sync_q;
  logic tick, tick_clear;

  uart_rx_state_t       state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_err_q, overrun_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 par_bad_q, par_bad_d;
  logic                 accept;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= UART_IDLE_LEVEL;
      rx_sync_q <= UART_IDLE_LEVEL;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Restart the tick phase on the clock the FSM leaves IDLE.
  assign tick_clear = (state_q == IDLE) && (rx_sync_q == 1'b0);

  uart_baud_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(tick_clear),
    .tick (tick)
  );

  assign accept = rx_valid_q && rx_ready;

  // Next-state, sampling and frame-completion logic.
  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    par_bad_d     = par_bad_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;
    parity_err_d  = 1'b0;

    if (accept) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (rx_sync_q == 1'b0) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end

      START: begin
        if (tick) begin
          if (tick_cnt_q == TICK_HALF) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            par_bad_d  = 1'b0;
            // A high line at mid start bit is a glitch, not a frame.
            state_d    = rx_sync_q ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (tick_cnt_q == TICK_FULL) begin
            tick_cnt_d = '0;
            shift_d    = {rx_sync_q, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d   = PARITY;
`else
              state_d   = STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (tick_cnt_q == TICK_FULL) begin
            tick_cnt_d = '0;
            // Data plus parity bit must XOR to the configured sense.
            par_bad_d  = (uart_xor_bits(UART_MAX_DATA_BITS'(shift_q)) ^ rx_sync_q)
                         != 1'(PARITY_ODD);
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
`endif

      STOP: begin
        if (tick) begin
          if (tick_cnt_q == TICK_FULL) begin
            tick_cnt_d = '0;
            if (rx_sync_q == 1'b0) begin
              frame_err_d = 1'b1;
              bit_cnt_d   = '0;
              state_d     = IDLE;
            end else if (bit_cnt_q == LAST_STOP) begin
              bit_cnt_d = '0;
              state_d   = IDLE;
              // Deliver if the output slot is free or being emptied now.
              if (!rx_valid_q || accept) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
              end else begin
                overrun_err_d = 1'b1;
              end
              parity_err_d = par_bad_q;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM, counters, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      par_bad_q     <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      parity_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      par_bad_q     <= par_bad_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
      parity_err_q  <= parity_err_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = (state_q != IDLE);

`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  logic parity_unused;
  assign parity_unused = parity_err_q ^ 1'(PARITY_ODD);
  assign parity_err    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: a frame-level model predicts delivered words,
// overrun/frame/parity events and their arrival cycle; a compare process
// checks the DUT against it every clock. A second instance covers the
// 5-data-bit, 2-stop-bit configuration.
module tb_uart_rx_param;

  localparam int CLK_DIV    = 4;
  localparam int OS         = 16;
  localparam int BIT        = CLK_DIV * OS;
  localparam int PARITY_ODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_a, rx_b, ready_a, ready_b;
  logic [7:0] data_a;
  logic [4:0] data_b;
  logic       valid_a, fe_a, ov_a, pe_a, busy_a;
  logic       valid_b, fe_b, ov_b, pe_b, busy_b;

  uart_rx_param #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .DATA_BITS(8), .STOP_BITS(1),
                  .PARITY_ODD(PARITY_ODD)) dut (
    .clk(clk), .reset(reset), .rx(rx_a), .rx_data(data_a), .rx_valid(valid_a),
    .rx_ready(ready_a), .frame_err(fe_a), .overrun_err(ov_a), .parity_err(pe_a),
    .busy(busy_a));

  uart_rx_param #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .DATA_BITS(5), .STOP_BITS(2),
                  .PARITY_ODD(PARITY_ODD)) dut5 (
    .clk(clk), .reset(reset), .rx(rx_b), .rx_data(data_b), .rx_valid(valid_b),
    .rx_ready(ready_b), .frame_err(fe_b), .overrun_err(ov_b), .parity_err(pe_b),
    .busy(busy_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- frame-level model ----------------
  // kind: 1 = word delivered, 2 = overrun, 3 = framing error
  typedef struct {
    int         kind;
    logic [7:0] data;
    bit         par;
    int         cyc;
  } ev_t;

  ev_t        evq[$];
  bit         mdl_valid = 1'b0;
  logic [7:0] mdl_word  = 8'h00;

  int vcyc_a = 0, fe_cnt_a = 0, ov_cnt_a = 0, pe_cnt_a = 0, last_rise_a = 0;
  int vrise_b = 0, fe_cnt_b = 0;
  logic [4:0] last_b = 5'h00;
  logic prev_valid_a = 1'b0, prev_valid_b = 1'b0;
  bit   rise;
  int   obs_kind;
  ev_t  e_obs;

  // Compare process: every event seen on the DUT outputs must be the next
  // one the model predicts, at the predicted time, with the predicted word.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid_a = 1'b0;
      prev_valid_b = 1'b0;
    end else begin
      rise = valid_a && !prev_valid_a;
      if (valid_a) vcyc_a++;
      if (fe_a) fe_cnt_a++;
      if (ov_a) ov_cnt_a++;
      if (pe_a) pe_cnt_a++;
      if (rise) last_rise_a = cyc;
      if (rise || ov_a || fe_a) begin
        obs_kind = fe_a ? 3 : (ov_a ? 2 : 1);
        if (evq.size() == 0) begin
          check("unexpected_event", 64'(obs_kind), 64'd0);
        end else begin
          e_obs = evq.pop_front();
          check("event_kind", 64'(obs_kind), 64'(e_obs.kind));
          check("event_time", 64'(cyc), (cyc >= e_obs.cyc - 2 && cyc <= e_obs.cyc + 2)
                                        ? 64'(cyc) : 64'(e_obs.cyc));
          check("parity_flag", 64'(pe_a), 64'(e_obs.par));
          if (e_obs.kind == 1) begin
            check("rx_data_load", 64'(data_a), 64'(e_obs.data));
            mdl_word = e_obs.data;
          end
        end
      end else begin
        if (evq.size() != 0 && cyc > evq[0].cyc + 2) begin
          check("event_timeout", 64'(cyc), 64'(evq[0].cyc));
          void'(evq.pop_front());
        end
        if (pe_a) check("stray_parity", 64'(pe_a), 64'd0);
      end
      if (valid_a && !rise) check("rx_data_held", 64'(data_a), 64'(mdl_word));
      prev_valid_a = valid_a;

      if (valid_b && !prev_valid_b) begin
        vrise_b++;
        last_b = data_b;
      end
      if (fe_b) fe_cnt_b++;
      prev_valid_b = valid_b;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) rx_a = v;
    else            rx_b = v;
  endtask

  // Drive one frame; force_par < 0 sends the correct parity bit. bad_stop is
  // the index of a stop bit driven low (-1 for none). When 'model' is set the
  // expected outcome is queued for the compare process.
  task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                            input int nstop, input int bad_stop, input int force_par,
                            input bit model);
    int   k;
    logic dpar, pb;
    ev_t  e;
    k    = cyc;
    dpar = 1'b0;
    for (int i = 0; i < nbits; i++) dpar ^= data[i];
    pb = (force_par >= 0) ? 1'(force_par) : (dpar ^ 1'(PARITY_ODD));
    if (model) begin
      e.data = data[7:0];
      e.par  = (P == 1) && ((dpar ^ pb) != 1'(PARITY_ODD));
      if (bad_stop >= 0) begin
        e.kind = 3;
        e.par  = 1'b0;
        e.cyc  = k + BIT / 2 + 3 + BIT * (nbits + P + bad_stop + 1);
      end else begin
        e.cyc = k + BIT / 2 + 3 + BIT * (nbits + P + nstop);
        if (!mdl_valid || ready_a) begin
          e.kind = 1;
          if (!ready_a) mdl_valid = 1'b1;
        end else begin
          e.kind = 2;
        end
      end
      evq.push_back(e);
    end
    set_line(which, 1'b0);
    wait_clks(BIT);
    for (int i = 0; i < nbits; i++) begin
      set_line(which, data[i]);
      wait_clks(BIT);
    end
    if (P == 1) begin
      set_line(which, pb);
      wait_clks(BIT);
    end
    for (int s = 0; s < nstop; s++) begin
      if (s == bad_stop) begin
        set_line(which, 1'b0);
        wait_clks(40);
        set_line(which, 1'b1);
        wait_clks(BIT - 40);
      end else begin
        set_line(which, 1'b1);
        wait_clks(BIT);
      end
    end
    set_line(which, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  int snap_v, snap_fe, snap_ov, snap_pe, k_a5;

  initial begin
    reset   = 1'b1;
    rx_a    = 1'b1;
    rx_b    = 1'b1;
    ready_a = 1'b1;
    ready_b = 1'b1;
    wait_clks(3);
    check("reset_rx_valid", 64'(valid_a), 64'd0);
    check("reset_rx_data", 64'(data_a), 64'd0);
    check("reset_busy", 64'(busy_a), 64'd0);
    check("reset_errs", 64'({fe_a, ov_a, pe_a}), 64'd0);
    reset = 1'b0;
    wait_clks(BIT);

    // 0xA5 with the consumer ready: single valid clock, no flags.
    snap_v = vcyc_a; snap_fe = fe_cnt_a; snap_ov = ov_cnt_a; snap_pe = pe_cnt_a;
    k_a5 = cyc;
    send_frame(0, 9'h0A5, 8, 1, -1, -1, 1'b1);
    wait_clks(2 * BIT);
    check("a5_data", 64'(data_a), 64'hA5);
    check("a5_valid_clks", 64'(vcyc_a - snap_v), 64'd1);
    check("a5_no_errs", 64'((fe_cnt_a - snap_fe) + (ov_cnt_a - snap_ov) + (pe_cnt_a - snap_pe)), 64'd0);
    check("a5_busy_low", 64'(busy_a), 64'd0);
    check("a5_latency", 64'(last_rise_a - k_a5),
          ((last_rise_a - k_a5 >= 35 + 64 * (9 + P) - 2) &&
           (last_rise_a - k_a5 <= 35 + 64 * (9 + P) + 2))
          ? 64'(last_rise_a - k_a5) : 64'(35 + 64 * (9 + P)));

    // Back-to-back 0x00 then 0xFF with the consumer stalled.
    ready_a = 1'b0;
    snap_ov = ov_cnt_a;
    send_frame(0, 9'h000, 8, 1, -1, -1, 1'b1);
    send_frame(0, 9'h0FF, 8, 1, -1, -1, 1'b1);
    wait_clks(2 * BIT);
    check("ovr_valid_held", 64'(valid_a), 64'd1);
    check("ovr_data_kept", 64'(data_a), 64'h00);
    check("ovr_pulses", 64'(ov_cnt_a - snap_ov), 64'd1);
    ready_a   = 1'b1;
    mdl_valid = 1'b0;
    wait_clks(2);
    check("ovr_drained", 64'(valid_a), 64'd0);

    // Short low glitch on the idle line: false start, nothing reported.
    snap_v = vcyc_a; snap_fe = fe_cnt_a;
    rx_a = 1'b0;
    wait_clks(3 * CLK_DIV);
    rx_a = 1'b1;
    wait_clks(2 * BIT);
    check("glitch_busy", 64'(busy_a), 64'd0);
    check("glitch_no_valid", 64'(vcyc_a - snap_v), 64'd0);
    check("glitch_no_fe", 64'(fe_cnt_a - snap_fe), 64'd0);

    // 0x3C with a low stop bit, then a clean 0x12.
    snap_v = vcyc_a; snap_fe = fe_cnt_a;
    send_frame(0, 9'h03C, 8, 1, 0, -1, 1'b1);
    wait_clks(3 * BIT);
    check("fe_pulses", 64'(fe_cnt_a - snap_fe), 64'd1);
    check("fe_no_valid", 64'(vcyc_a - snap_v), 64'd0);
    send_frame(0, 9'h012, 8, 1, -1, -1, 1'b1);
    wait_clks(2 * BIT);
    check("after_fe_data", 64'(data_a), 64'h12);

    // Reset in the middle of the data bits of 0x5A.
    rx_a = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 4; i++) begin
      rx_a = (i % 2 == 1);
      wait_clks(BIT);
    end
    check("mid_busy", 64'(busy_a), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_data", 64'(data_a), 64'd0);
    check("async_rst_valid", 64'(valid_a), 64'd0);
    check("async_rst_busy", 64'(busy_a), 64'd0);
    check("async_rst_errs", 64'({fe_a, ov_a, pe_a}), 64'd0);
    rx_a      = 1'b1;
    mdl_word  = 8'h00;
    mdl_valid = 1'b0;
    wait_clks(3);
    reset = 1'b0;
    wait_clks(BIT);
    send_frame(0, 9'h05A, 8, 1, -1, -1, 1'b1);
    wait_clks(2 * BIT);
    check("post_rst_data", 64'(data_a), 64'h5A);

`ifdef UART_RX_PARITY_EN
    // Even parity, 0x07 (three ones) with parity bit 0: mismatch, word kept.
    snap_pe = pe_cnt_a; snap_v = vcyc_a;
    send_frame(0, 9'h007, 8, 1, -1, 0, 1'b1);
    wait_clks(2 * BIT);
    check("par_data", 64'(data_a), 64'h07);
    check("par_valid", 64'(vcyc_a - snap_v), 64'd1);
    check("par_err_pulses", 64'(pe_cnt_a - snap_pe), 64'd1);
`endif

    // Five data bits, two stop bits.
    send_frame(1, 9'h015, 5, 2, -1, -1, 1'b0);
    wait_clks(2 * BIT);
    check("b5_valid_rises", 64'(vrise_b), 64'd1);
    check("b5_data", 64'(last_b), 64'h15);
    send_frame(1, 9'h00A, 5, 2, 1, -1, 1'b0);
    wait_clks(3 * BIT);
    check("b5_fe_second_stop", 64'(fe_cnt_b), 64'd1);
    check("b5_no_new_valid", 64'(vrise_b), 64'd1);

    for (int i = 0; i < 2000 && evq.size() != 0; i++) wait_clks(1);
    check("events_pending", 64'(evq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
